// File: rtl/subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and its width.
package subtractor_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : subtractor_pkg

// File: rtl/subtractor_1bit_full.sv
// One-bit full subtractor: difference and borrow-out for a - b - borrow-in.
module subtractor_1bit_full (
    input  logic a_i,
    input  logic b_i,
    input  logic brw_i,
    output logic diff_o,
    output logic brw_o
);

    assign diff_o = a_i ^ b_i ^ brw_i;
    assign brw_o  = (~a_i & b_i) | (~(a_i ^ b_i) & brw_i);

endmodule : subtractor_1bit_full

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: accepts an operand pair, resolves one bit per cycle LSB first,
// then holds difference, unsigned borrow and signed overflow until the sink takes them.
//
// state | meaning
// IDLE  | ready for operands; previous result still visible
// CALC  | one bit per cycle, DATA_WIDTH cycles
// DONE  | result valid, waiting for i_rdy
module subtractor_serial
    import subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_brw,
    output logic                  o_ovf
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  brw_q;
    logic                  a_msb_q;
    logic                  b_msb_q;
    logic                  brw_out_q;
    logic                  ovf_q;
    logic                  diff_d;
    logic                  brw_d;

    subtractor_1bit_full u_bit (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .brw_i  (brw_q),
        .diff_o (diff_d),
        .brw_o  (brw_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            brw_q     <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            brw_out_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_vld) begin
                        a_q       <= i_num_a;
                        b_q       <= i_num_b;
                        a_msb_q   <= i_num_a[DATA_WIDTH-1];
                        b_msb_q   <= i_num_b[DATA_WIDTH-1];
                        res_q     <= '0;
                        cnt_q     <= '0;
                        brw_q     <= 1'b0;
                        brw_out_q <= 1'b0;
                        ovf_q     <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= {diff_d, res_q[DATA_WIDTH-1:1]};
                    brw_q <= brw_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        // diff_d is the result MSB on this final bit
                        brw_out_q <= brw_d;
                        ovf_q     <= (a_msb_q != b_msb_q) && (diff_d != a_msb_q);
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rdy = (state_q == IDLE);
    assign o_vld = (state_q == DONE);
    assign o_res = res_q;
    assign o_brw = brw_out_q;
    assign o_ovf = ovf_q;

endmodule : subtractor_serial

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial at DATA_WIDTH=8: directed transactions with literal
// expectations plus a per-cycle transaction-level model of the handshake and arithmetic.
module tb_subtractor_serial;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_vld;
    logic         o_rdy;
    logic [W-1:0] i_num_a;
    logic [W-1:0] i_num_b;
    logic         o_vld;
    logic         i_rdy;
    logic [W-1:0] o_res;
    logic         o_brw;
    logic         o_ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    subtractor_serial #(.DATA_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_res   (o_res),
        .o_brw   (o_brw),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one operand pair in flight, result due W edges after acceptance.
    bit         m_busy = 1'b0;
    int         m_acc_cyc = 0;
    logic [W-1:0] m_res = '0;
    logic       m_brw = 1'b0;
    logic       m_ovf = 1'b0;

    always @(negedge i_clk) begin
        bit exp_vld;
        int sa, sb, sd;
        if (!i_rst_n) begin
            m_busy = 1'b0;
            m_res  = '0;
            m_brw  = 1'b0;
            m_ovf  = 1'b0;
            chk("mon_rst_rdy", 64'(o_rdy), 64'(1));
            chk("mon_rst_vld", 64'(o_vld), 64'(0));
            chk("mon_rst_res", 64'(o_res), 64'(0));
            chk("mon_rst_brw", 64'(o_brw), 64'(0));
            chk("mon_rst_ovf", 64'(o_ovf), 64'(0));
        end else begin
            exp_vld = m_busy && ((cyc - m_acc_cyc) >= W);
            chk("mon_vld", 64'(o_vld), 64'(exp_vld));
            chk("mon_rdy", 64'(o_rdy), 64'(!m_busy));
            if (!m_busy || exp_vld) begin
                chk("mon_res", 64'(o_res), 64'(m_res));
                chk("mon_brw", 64'(o_brw), 64'(m_brw));
                chk("mon_ovf", 64'(o_ovf), 64'(m_ovf));
            end
            if (!m_busy && i_vld) begin
                m_busy    = 1'b1;
                m_acc_cyc = cyc + 1;
                m_res     = W'(i_num_a - i_num_b);
                m_brw     = (i_num_a < i_num_b);
                sa        = int'($signed(i_num_a));
                sb        = int'($signed(i_num_b));
                sd        = sa - sb;
                m_ovf     = (sd > 127) || (sd < -128);
            end else if (exp_vld && i_rdy) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                           input bit noise, input logic [W-1:0] e_res, input bit e_brw,
                           input bit e_ovf);
        int k;
        bit seen;
        i_num_a = a;
        i_num_b = b;
        i_vld   = 1'b1;
        i_rdy   = (hold == 0);
        @(posedge i_clk); #1;
        i_vld = 1'b0;
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < 20) begin
            if (noise) begin
                i_vld   = 1'($urandom);
                i_num_a = W'($urandom);
                i_num_b = W'($urandom);
            end
            @(posedge i_clk); #1;
            k++;
            if (o_vld) seen = 1'b1;
        end
        i_vld = 1'b0;
        chk("vld_seen", 64'(seen), 64'(1));
        chk("latency", 64'(k), 64'(W));
        chk("res", 64'(o_res), 64'(e_res));
        chk("brw", 64'(o_brw), 64'(e_brw));
        chk("ovf", 64'(o_ovf), 64'(e_ovf));
        for (int h = 1; h < hold; h++) begin
            if (noise) begin
                i_vld   = 1'($urandom);
                i_num_a = W'($urandom);
            end
            @(posedge i_clk); #1;
            chk("hold_vld", 64'(o_vld), 64'(1));
            chk("hold_rdy", 64'(o_rdy), 64'(0));
            chk("hold_res", 64'(o_res), 64'(e_res));
            chk("hold_brw", 64'(o_brw), 64'(e_brw));
            chk("hold_ovf", 64'(o_ovf), 64'(e_ovf));
        end
        i_vld = 1'b0;
        i_rdy = 1'b1;
        @(posedge i_clk); #1;
        chk("post_vld", 64'(o_vld), 64'(0));
        chk("post_rdy", 64'(o_rdy), 64'(1));
        chk("post_res", 64'(o_res), 64'(e_res));
        i_rdy = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_vld   = 1'b0;
        i_rdy   = 1'b0;
        i_num_a = '0;
        i_num_b = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_rdy", 64'(o_rdy), 64'(1));
        chk("rst_vld", 64'(o_vld), 64'(0));
        chk("rst_res", 64'(o_res), 64'(0));
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_txn(8'h05, 8'h03, 0, 1'b0, 8'h02, 1'b0, 1'b0);
        run_txn(8'h00, 8'h01, 0, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_txn(8'h80, 8'h01, 0, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_txn(8'h7F, 8'hFF, 5, 1'b0, 8'h80, 1'b1, 1'b1);
        run_txn(8'h80, 8'h7F, 0, 1'b0, 8'h01, 1'b0, 1'b1);

        // reset in the middle of CALC, then a fresh transaction
        i_num_a = 8'h10;
        i_num_b = 8'h20;
        i_vld   = 1'b1;
        @(posedge i_clk); #1;
        i_vld = 1'b0;
        chk("mid_calc_rdy", 64'(o_rdy), 64'(0));
        repeat (4) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 64'(o_rdy), 64'(1));
        chk("midrst_vld", 64'(o_vld), 64'(0));
        chk("midrst_res", 64'(o_res), 64'(0));
        chk("midrst_brw", 64'(o_brw), 64'(0));
        chk("midrst_ovf", 64'(o_ovf), 64'(0));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        run_txn(8'h09, 8'h09, 0, 1'b0, 8'h00, 1'b0, 1'b0);

        run_txn(8'h3C, 8'h5A, 0, 1'b1, 8'hE2, 1'b1, 1'b0);
        run_txn(8'hC8, 8'h14, 3, 1'b1, 8'hB4, 1'b0, 1'b0);

        repeat (3) @(posedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_subtractor_serial
